display_msg_scheduler: RTL and testbench

Sequencer that turns the byte stream from the UART receiver into the 16-bit, four-character word consumed by the seven-segment anode driver. It buffers received bytes as a nibble message and shows it statically when it fits in four digits, or scrolls it one digit per step when longer. Receive errors replace the display with an error pattern. It sits between the UART receiver and the anode driver's `word` input.

---
 rtl/display_msg_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_display_msg_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/display_msg_scheduler.sv
// display_msg_scheduler
//   Buffers bytes from the UART receiver as a nibble message and drives the
//   four-digit seven-segment word. Messages of up to four nibbles are shown
//   statically (left-aligned, blank padded). Longer messages scroll one digit
//   every SCROLL_DIV cycles. A receive error replaces the display with an
//   error pattern until the next good byte.
//
// Ports
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   rx_data   : received byte, valid with rx_valid
//   rx_valid  : one-cycle strobe per received byte
//   rx_perror : parity error flag, sampled with rx_valid
//   rx_ferror : framing error flag, sampled with rx_valid
//   clear     : synchronous message clear (wins over rx_valid)
//   word      : display word, [15:12] leftmost digit, [3:0] rightmost
//   msg_len   : number of bytes held
//   overflow  : sticky, a good byte was dropped because the buffer was full
//   error     : high while the error pattern is displayed
module display_msg_scheduler #(
  parameter int         DEPTH      = 8,
  parameter int         SCROLL_DIV = 25_000_000,
  parameter logic [3:0] BLANK_CHAR = 4'hC,
  parameter logic [3:0] ERR_CHAR   = 4'hE,
  localparam int        AW         = $clog2(DEPTH),
  localparam int        LW         = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_perror,
  input  logic          rx_ferror,
  input  logic          clear,
  output logic [15:0]   word,
  output logic [LW-1:0] msg_len,
  output logic          overflow,
  output logic          error
);

  localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SHOW,
    ST_SCROLL,
    ST_ERROR
  } state_t;

  state_t        state_reg, state_next;
  logic [LW-1:0] len_reg, len_next;
  logic [LW-1:0] pos_reg, pos_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ovf_reg, ovf_next;
  logic          err_reg, err_next;
  logic [15:0]   word_reg, word_next;

  logic          wr_en;
  logic [7:0]    mem [DEPTH];

  logic          good_byte, bad_byte;
  logic [LW:0]   n_reg;      // nibble count N = 2*msg_len
  logic [LW-1:0] len_inc;
  logic [15:0]   disp;       // SHOW/SCROLL window, leftmost digit in [15:12]

  assign good_byte = rx_valid & ~rx_perror & ~rx_ferror;
  assign bad_byte  = rx_valid & (rx_perror | rx_ferror);
  assign n_reg     = {len_reg, 1'b0};
  assign len_inc   = len_reg + LW'(1);

  // Next-state and control
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    pos_next   = pos_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    err_next   = err_reg;
    wr_en      = 1'b0;

    // Step timer only runs while scrolling; appends leave it untouched.
    if (state_reg == ST_SCROLL) begin
      if (cnt_reg == CW'(SCROLL_DIV - 1)) begin
        cnt_next = '0;
        pos_next = ({1'b0, pos_reg} + (LW+1)'(1) == n_reg) ? '0 : pos_reg + LW'(1);
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end

    if (clear) begin
      state_next = ST_EMPTY;
      len_next   = '0;
      pos_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
      err_next   = 1'b0;
    end else if (bad_byte) begin
      state_next = ST_ERROR;
      len_next   = '0;
      pos_next   = '0;
      cnt_next   = '0;
      err_next   = 1'b1;
    end else if (good_byte) begin
      if (len_reg == LW'(DEPTH)) begin
        ovf_next = 1'b1;
      end else begin
        wr_en    = 1'b1;
        len_next = len_inc;
        unique case (state_reg)
          ST_EMPTY, ST_ERROR: begin
            // len_reg is 0 here, so the byte lands at index 0
            state_next = ST_SHOW;
            err_next   = 1'b0;
            pos_next   = '0;
            cnt_next   = '0;
          end
          ST_SHOW: begin
            if (len_inc > LW'(2)) begin
              state_next = ST_SCROLL;
              pos_next   = '0;
              cnt_next   = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-digit nibble fetch. In SCROLL the index is (pos+i) mod N; since
  // pos < N and N > 4 there, one conditional subtraction suffices.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_digit
      logic [LW+1:0] sum;
      logic [LW-1:0] idx;
      logic [7:0]    byte_v;
      logic [3:0]    d;
      always_comb begin
        sum = {2'b00, pos_reg} + (LW+2)'(gi);
        if (sum >= {1'b0, n_reg}) begin
          sum = sum - {1'b0, n_reg};
        end
        idx    = (state_reg == ST_SCROLL) ? sum[LW-1:0] : LW'(gi);
        byte_v = mem[idx[LW-1:1]];
        d      = idx[0] ? byte_v[3:0] : byte_v[7:4];
        if (state_reg == ST_SHOW && !((LW+1)'(gi) < n_reg)) begin
          d = BLANK_CHAR;
        end
      end
      assign disp[15-4*gi -: 4] = d;
    end
  endgenerate

  always_comb begin
    word_next = {4{BLANK_CHAR}};
    unique case (state_reg)
      ST_EMPTY:  word_next = {4{BLANK_CHAR}};
      ST_ERROR:  word_next = {4{ERR_CHAR}};
      default:   word_next = disp;
    endcase
  end

  // Message buffer; contents need no reset since msg_len gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[len_reg[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
      len_reg   <= '0;
      pos_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
      word_reg  <= {4{BLANK_CHAR}};
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      pos_reg   <= pos_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      err_reg   <= err_next;
      word_reg  <= word_next;
    end
  end

  assign word     = word_reg;
  assign msg_len  = len_reg;
  assign overflow = ovf_reg;
  assign error    = err_reg;

endmodule

// File: tb/tb_display_msg_scheduler.sv
module tb_display_msg_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_perror = 1'b0;
  logic        rx_ferror = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] word;
  logic [2:0]  msg_len;
  logic        overflow;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  display_msg_scheduler #(
    .DEPTH(4),
    .SCROLL_DIV(4),
    .BLANK_CHAR(4'hC),
    .ERR_CHAR(4'hE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_perror(rx_perror),
    .rx_ferror(rx_ferror),
    .clear(clear),
    .word(word),
    .msg_len(msg_len),
    .overflow(overflow),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  // Presents one byte for one cycle; returns at the falling edge after the
  // sampling edge (msg_len/error updated, word not yet).
  task automatic send(input logic [7:0] b, input logic pe, input logic fe);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; rx_perror = pe; rx_ferror = fe;
    @(negedge clk);
    rx_valid = 1'b0; rx_perror = 1'b0; rx_ferror = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [15:0] w;
    logic        has5;

    // Reset state
    cycles(3);
    reset = 1'b0;
    chk("rst_word", word, 16'hCCCC);
    chk("rst_len", 16'(msg_len), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_err", 16'(error), 16'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_word", word, 16'hCCCC);
    end

    // Static display
    send(8'h12, 1'b0, 1'b0);
    chk("len1", 16'(msg_len), 16'd1);
    chk("word_lat0", word, 16'hCCCC);
    @(negedge clk);
    chk("word_12CC", word, 16'h12CC);
    send(8'h34, 1'b0, 1'b0);
    @(negedge clk);
    chk("word_1234", word, 16'h1234);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("static_1234", word, 16'h1234);
    end

    // Scroll: byte 0x56 at edge k, steps land in word at k+5, k+9, ...
    send(8'h56, 1'b0, 1'b0);
    chk("len3", 16'(msg_len), 16'd3);
    @(negedge clk);
    chk("scr_start", word, 16'h1234);
    cycles(3);
    chk("scr_hold", word, 16'h1234);
    @(negedge clk);
    chk("scr_2345", word, 16'h2345);
    cycles(4); chk("scr_3456", word, 16'h3456);
    cycles(4); chk("scr_4561", word, 16'h4561);
    cycles(4); chk("scr_5612", word, 16'h5612);
    cycles(4); chk("scr_6123", word, 16'h6123);
    cycles(4); chk("scr_wrap", word, 16'h1234);

    // Parity error mid-scroll, then recovery
    send(8'h77, 1'b1, 1'b0);
    chk("pe_err", 16'(error), 16'd1);
    chk("pe_len", 16'(msg_len), 16'd0);
    @(negedge clk);
    chk("pe_word", word, 16'hEEEE);
    send(8'hAB, 1'b0, 1'b0);
    chk("pe_rec_err", 16'(error), 16'd0);
    chk("pe_rec_len", 16'(msg_len), 16'd1);
    @(negedge clk);
    chk("pe_rec_word", word, 16'hABCC);

    // Framing error, then recovery
    send(8'h77, 1'b0, 1'b1);
    chk("fe_err", 16'(error), 16'd1);
    chk("fe_len", 16'(msg_len), 16'd0);
    @(negedge clk);
    chk("fe_word", word, 16'hEEEE);
    send(8'hAB, 1'b0, 1'b0);
    chk("fe_rec_err", 16'(error), 16'd0);
    @(negedge clk);
    chk("fe_rec_word", word, 16'hABCC);

    // Clear, then five back-to-back bytes into a 4-byte buffer
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("clr_len", 16'(msg_len), 16'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      rx_data = 8'(i); rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("full_len", 16'(msg_len), 16'd4);
    chk("full_ovf", 16'(overflow), 16'd1);
    chk("full_word", word, 16'h0102);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      w = word;
      has5 = (w[15:12] == 4'h5) || (w[11:8] == 4'h5) || (w[7:4] == 4'h5) || (w[3:0] == 4'h5);
      chk("no_5", 16'(has5), 16'd0);
    end

    // Clear wins over a simultaneous byte
    @(negedge clk);
    clear = 1'b1; rx_data = 8'h99; rx_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; rx_valid = 1'b0;
    chk("clrv_len", 16'(msg_len), 16'd0);
    chk("clrv_ovf", 16'(overflow), 16'd0);
    chk("clrv_err", 16'(error), 16'd0);
    @(negedge clk);
    chk("clrv_word", word, 16'hCCCC);

    // Asynchronous reset during SCROLL with overflow set
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    send(8'h56, 1'b0, 1'b0);
    send(8'h78, 1'b0, 1'b0);
    send(8'h9A, 1'b0, 1'b0);
    cycles(6);
    chk("pre_rst_ovf", 16'(overflow), 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_word", word, 16'hCCCC);
    chk("arst_len", 16'(msg_len), 16'd0);
    chk("arst_ovf", 16'(overflow), 16'd0);
    chk("arst_err", 16'(error), 16'd0);
    cycles(2);
    reset = 1'b0;
    send(8'h12, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst", word, 16'h12CC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
